// File: rtl/matrix_stream_serializer.sv
// rtl/matrix_stream_serializer.sv - captures a flat matrix and streams its active NxN block one element per beat
module matrix_stream_serializer #(
  parameter int DIM = 5,
  parameter int EW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM*DIM*EW-1:0] A_flat,
  input  logic [1:0]            size,
  input  logic                  col_major,
  output logic                  busy,
  output logic [EW-1:0]         elem_data,
  output logic [2:0]            elem_row,
  output logic [2:0]            elem_col,
  output logic                  elem_valid,
  input  logic                  elem_ready,
  output logic                  elem_last,
  output logic                  done
);

  localparam int XW = $clog2(DIM*DIM);
  localparam int IW = $clog2(DIM*DIM*EW);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state, state_next;
  logic [DIM*DIM*EW-1:0] mat;
  logic [2:0]            n_last;   // active dimension minus one, kept so the wrap compare is direct
  logic                  cmaj;
  logic [2:0]            row, col;
  logic [XW-1:0]         idx;
  logic [IW-1:0]         base;
  logic                  at_last;
  logic                  xfer;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture on accepted start, then walk row/col on every transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      mat    <= '0;
      n_last <= '0;
      cmaj   <= 1'b0;
      row    <= '0;
      col    <= '0;
    end else if (state == IDLE && start) begin
      mat    <= A_flat;
      n_last <= {1'b0, size} + 3'd1;
      cmaj   <= col_major;
      row    <= '0;
      col    <= '0;
    end else if (xfer) begin
      if (cmaj) begin
        if (row == n_last) begin
          row <= '0;
          col <= col + 3'd1;
        end else begin
          row <= row + 3'd1;
        end
      end else begin
        if (col == n_last) begin
          col <= '0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

  // Next state and outputs; element fields are zeroed outside STREAM so idle reads 0
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    elem_data  = '0;
    elem_row   = '0;
    elem_col   = '0;
    xfer       = 1'b0;
    // Stride is always DIM regardless of the active size
    idx        = XW'(row) * XW'(DIM) + XW'(col);
    base       = IW'(idx) * IW'(EW);
    at_last    = (row == n_last) && (col == n_last);

    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        elem_valid = 1'b1;
        elem_last  = at_last;
        elem_data  = mat[base +: EW];
        elem_row   = row;
        elem_col   = col;
        xfer       = elem_ready;
        if (elem_ready && at_last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_stream_serializer.sv
// tb/tb_matrix_stream_serializer.sv - directed self-checking bench for matrix_stream_serializer
module tb_matrix_stream_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [199:0] A_flat;
  logic [1:0]   size;
  logic         col_major;
  logic         busy;
  logic [7:0]   elem_data;
  logic [2:0]   elem_row;
  logic [2:0]   elem_col;
  logic         elem_valid;
  logic         elem_ready;
  logic         elem_last;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [199:0] pat;
  logic [6:0]   tog_pat = 7'b1101001;   // bit i = ready in stream cycle i: 1,0,0,1,0,1,1

  matrix_stream_serializer #(.DIM(5), .EW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A_flat     (A_flat),
    .size       (size),
    .col_major  (col_major),
    .busy       (busy),
    .elem_data  (elem_data),
    .elem_row   (elem_row),
    .elem_col   (elem_col),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_last  (elem_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [199:0] make_pat();
    logic [199:0] p = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        p[(r*5+c)*8 +: 8] = {r[3:0], c[3:0]};
    return p;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_valid"}, elem_valid, 0);
    check({tag, "_data"},  elem_data, 0);
    check({tag, "_row"},   elem_row, 0);
    check({tag, "_col"},   elem_col, 0);
    check({tag, "_last"},  elem_last, 0);
    check({tag, "_done"},  done, 0);
  endtask

  // Called at a falling edge; returns at the falling edge after the capturing edge
  task automatic do_start(input logic [1:0] sz, input logic cm);
    A_flat     = pat;
    size       = sz;
    col_major  = cm;
    start      = 1'b1;
    elem_ready = 1'b1;   // valid is still low, so this must not advance anything
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples each cycle at the falling edge, then drives ready for the next rising edge
  task automatic run_stream(input int n, input bit cm, input bit toggle, input bit disturb);
    int beat = 0;
    int cyc  = 0;
    int r, c;
    bit rdy;
    while (beat < n*n && cyc < 300) begin
      r = cm ? beat % n : beat / n;
      c = cm ? beat / n : beat % n;
      check("valid", elem_valid, 1);
      check("data",  elem_data, {24'd0, r[3:0], c[3:0]});
      check("row",   elem_row, r);
      check("col",   elem_col, c);
      check("last",  elem_last, (beat == n*n-1) ? 1 : 0);
      check("busy",  busy, 1);
      check("done_mid", done, 0);
      rdy = toggle ? tog_pat[cyc % 7] : 1'b1;
      elem_ready = rdy;
      if (disturb && beat == 10) begin
        start     = 1'b1;
        A_flat    = ~pat;
        size      = 2'b00;
        col_major = ~cm;
      end else begin
        start = 1'b0;
      end
      if (rdy) beat++;
      cyc++;
      @(negedge clk);
    end
    start      = 1'b0;
    elem_ready = 1'b1;
    check("beats", beat, n*n);
    check("done_pulse", done, 1);
    check("done_valid", elem_valid, 0);
    check("done_busy",  busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  initial begin
    pat        = make_pat();
    rst        = 1'b1;
    start      = 1'b0;
    A_flat     = '0;
    size       = 2'b00;
    col_major  = 1'b0;
    elem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // 5x5 row-major, ready held high
    do_start(2'b11, 1'b0);
    run_stream(5, 1'b0, 1'b0, 1'b0);

    // 3x3 column-major, started in the cycle right after IDLE was re-entered
    do_start(2'b01, 1'b1);
    run_stream(3, 1'b1, 1'b0, 1'b0);

    // 2x2 row-major with ready toggling
    do_start(2'b00, 1'b0);
    run_stream(2, 1'b0, 1'b1, 1'b0);

    // 5x5 with start re-pulsed and inputs changed mid-stream
    do_start(2'b11, 1'b0);
    run_stream(5, 1'b0, 1'b0, 1'b1);

    // 4x4 aborted by reset after 7 beats
    do_start(2'b10, 1'b0);
    repeat (7) @(negedge clk);
    check("abort_pre_data", elem_data, 8'h13);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_no_valid", elem_valid, 0);
    end

    // Fresh 4x4 stream after abort
    do_start(2'b10, 1'b0);
    run_stream(4, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
